// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the multi-cycle integer divider.
package div_unit_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Restoring radix-2 divider for div.w/div.wu/mod.w/mod.wu; 33 cycles issue-to-done (1 on divide by zero).
// No queuing: starts are only accepted in IDLE, results are held until the next completed operation.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DIV_WD = DIV_W,
  parameter int CNT_WD = DIV_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DIV_WD-1:0] div_src1,
  input  logic [DIV_WD-1:0] div_src2,
  input  logic              div_cancel,
  output logic              div_busy,
  output logic              div_done,
  output logic [DIV_WD-1:0] div_result,
  output logic [DIV_WD-1:0] mod_result
);

  div_state_t        state, state_nxt;
  logic [CNT_WD-1:0] cnt;
  logic [DIV_WD-1:0] quo, rem, dvsr;
  logic              q_neg, r_neg;

  logic              accept, div_zero, last_step;
  logic [DIV_WD-1:0] src1_mag, src2_mag;
  logic [DIV_WD:0]   rem_sh;
  logic              no_borrow;
  logic [DIV_WD-1:0] diff, quo_nxt, rem_nxt;

  assign src1_mag  = (div_signed && div_src1[DIV_WD-1]) ? -div_src1 : div_src1;
  assign src2_mag  = (div_signed && div_src2[DIV_WD-1]) ? -div_src2 : div_src2;
  assign accept    = (state == DIV_IDLE) && div_start && !div_cancel;
  assign div_zero  = (div_src2 == '0);
  assign last_step = (cnt == CNT_WD'(DIV_WD - 1));

  // Shifted partial remainder can reach 2*divisor-1, hence the extra top bit.
  assign rem_sh    = {rem, quo[DIV_WD-1]};
  assign no_borrow = (rem_sh >= {1'b0, dvsr});
  assign diff      = rem_sh[DIV_WD-1:0] - dvsr;
  assign quo_nxt   = {quo[DIV_WD-2:0], no_borrow};
  assign rem_nxt   = no_borrow ? diff : rem_sh[DIV_WD-1:0];

  assign div_busy  = (state != DIV_IDLE);
  assign div_done  = (state == DIV_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (accept) state_nxt = div_zero ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (last_step) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
    if (div_cancel) state_nxt = DIV_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      quo   <= src1_mag;
      rem   <= '0;
      dvsr  <= src2_mag;
      q_neg <= div_signed & (div_src1[DIV_WD-1] ^ div_src2[DIV_WD-1]);
      r_neg <= div_signed & div_src1[DIV_WD-1];
    end else if (state == DIV_CALC && !div_cancel) begin
      cnt   <= cnt + CNT_WD'(1);
      quo   <= quo_nxt;
      rem   <= rem_nxt;
    end
  end

  // Results move only on the edge entering DONE; a cancelled final step leaves them untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_result <= '0;
      mod_result <= '0;
    end else if (accept && div_zero) begin
      div_result <= '1;
      mod_result <= div_src1;
    end else if (state == DIV_CALC && last_step && !div_cancel) begin
      div_result <= q_neg ? -quo_nxt : quo_nxt;
      mod_result <= r_neg ? -rem_nxt : rem_nxt;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a cycle-level reference model and per-cycle output checks.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] div_src1 = '0;
  logic [31:0] div_src2 = '0;
  logic        div_cancel = 1'b0;
  logic        div_busy, div_done;
  logic [31:0] div_result, mod_result;

  int total = 0;
  int bad = 0;

  div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .div_cancel (div_cancel),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_result (div_result),
    .mod_result (mod_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {quotient, remainder} from plain 64-bit division.
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sg);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    q = 32'(sa / sb);
    r = 32'(sa % sb);
    return {q, r};
  endfunction

  // Model: m_cnt = busy cycles remaining including the current one; DONE is the last.
  int          m_cnt;
  logic [31:0] m_q, m_r, p_q, p_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0;
      m_q   <= '0;
      m_r   <= '0;
      p_q   <= '0;
      p_r   <= '0;
    end else if (div_cancel) begin
      m_cnt <= 0;
    end else if (m_cnt == 0) begin
      if (div_start) begin
        if (div_src2 == 32'd0) begin
          m_cnt <= 1;
          {m_q, m_r} <= model_div(div_src1, div_src2, div_signed);
        end else begin
          m_cnt <= 33;
          {p_q, p_r} <= model_div(div_src1, div_src2, div_signed);
        end
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) begin
        m_q <= p_q;
        m_r <= p_r;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(div_busy), 32'(m_cnt != 0));
    chk("done", 32'(div_done), 32'(m_cnt == 1));
    chk("quotient", div_result, m_q);
    chk("remainder", mod_result, m_r);
  end

  // Starts one operation at the next edge, measures cycles to div_done, checks literal results.
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input int exp_lat,
                       input logic [31:0] eq, input logic [31:0] er);
    int lat;
    div_src1 = a;
    div_src2 = b;
    div_signed = sg;
    div_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_start = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (div_done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_q"}, div_result, eq);
    chk({nm, "_r"}, mod_result, er);
    @(negedge clk);
  endtask

  task automatic wait_no_done(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (div_done) seen++;
    end
    chk({nm, "_no_done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #1;
    chk("reset_busy", 32'(div_busy), 32'd0);
    chk("reset_done", 32'(div_done), 32'd0);
    chk("reset_q", div_result, 32'd0);
    chk("reset_r", mod_result, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op("u100_7", 32'd100, 32'd7, 1'b0, 32, 32'd14, 32'd2);
    do_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32, 32'hFFFF_FFFD, 32'd1);
    do_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32, 32'h8000_0000, 32'd0);
    do_op("u_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32, 32'd0, 32'h8000_0000);
    do_op("s_5_0", 32'd5, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 32'd5);
    do_op("u_5_0", 32'd5, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'd5);
    do_op("u_max_3", 32'hFFFF_FFFF, 32'd3, 1'b0, 32, 32'h5555_5555, 32'd0);

    // Cancel mid-CALC: outputs keep the 100/7 result.
    do_op("u100_7b", 32'd100, 32'd7, 1'b0, 32, 32'd14, 32'd2);
    div_src1 = 32'd9;
    div_src2 = 32'd3;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (9) @(negedge clk);
    div_cancel = 1'b1;
    @(negedge clk);
    div_cancel = 1'b0;
    chk("cancel_busy", 32'(div_busy), 32'd0);
    wait_no_done("cancel", 40);
    chk("cancel_q", div_result, 32'd14);
    chk("cancel_r", mod_result, 32'd2);

    // Start while busy is ignored.
    div_src1 = 32'd1000;
    div_src2 = 32'd7;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (5) @(negedge clk);
    div_src1 = 32'd50;
    div_src2 = 32'd5;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    for (int k = 0; k < 40 && !div_done; k++) @(negedge clk);
    chk("busy_start_done", 32'(div_done), 32'd1);
    chk("busy_start_q", div_result, 32'd142);
    chk("busy_start_r", mod_result, 32'd6);
    wait_no_done("ignored_start", 40);
    chk("ignored_q", div_result, 32'd142);

    // Cancel together with start in IDLE: not accepted.
    div_src1 = 32'd50;
    div_src2 = 32'd5;
    div_start = 1'b1;
    div_cancel = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    div_cancel = 1'b0;
    chk("cancel_start_busy", 32'(div_busy), 32'd0);
    wait_no_done("cancel_start", 40);

    // Asynchronous reset between edges mid-CALC.
    div_src1 = 32'd77;
    div_src2 = 32'd4;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_busy", 32'(div_busy), 32'd0);
    chk("areset_q", div_result, 32'd0);
    chk("areset_r", mod_result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op("u20_4", 32'd20, 32'd4, 1'b0, 32, 32'd5, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
